store_aligner: RTL and testbench
================================

# store_aligner

Store-path byte-lane formatter and write sequencer between the execute stage and the data-memory write port. Accepts one store request (address, register data, width), shifts the data into the correct byte lanes, and generates a 4-bit byte write-enable. Drives a valid/ready beat to memory, splitting stores that cross a word boundary into two beats. It is the write-side counterpart of the load-data extractor.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- st_valid  input  1  store request present
- st_ready  output  1  block can accept a request this cycle
- st_addr  input  32  byte address, unaligned allowed
- st_data  input  32  store data, right-justified (rs2)
- st_sel  input  2  width: 00 sw, 01 sh, 10 sb, 11 reserved
- mem_valid  output  1  write beat valid
- mem_ready  input  1  memory accepts beat
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-shifted write data
- mem_we  output  4  byte write-enable, bit i = byte lane i
- st_done  output  1  one-cycle pulse: final beat of a store accepted
- st_err  output  1  one-cycle pulse: request rejected (reserved sel, or misaligned with split disabled)

## Operation
- Width mask m: sw 4'b1111, sh 4'b0011, sb 4'b0001. off = st_addr[1:0].
- FSM states: IDLE, BEAT0, BEAT1, ERR.
- IDLE: st_ready=1. On st_valid: latch addr, data, sel. Reserved sel -> ERR. Misaligned (off + bytes > 4) without split -> ERR. Otherwise -> BEAT0.
- BEAT0: mem_addr = word(addr); mem_wdata = data << 8*off; mem_we = (m << off)[3:0]. On mem_ready: -> BEAT1 if crossing, else pulse st_done and -> IDLE.
- BEAT1 (split only): mem_addr = word(addr)+4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000); mem_wdata = data >> 8*(4-off); mem_we = m >> (4-off). On mem_ready: pulse st_done, -> IDLE.
- ERR: no memory beat; st_err=1 for one cycle; -> IDLE.
- Unused lanes of mem_wdata are 0.
- Crossing cases: sw off 1/2/3; sh off 3. sb never crosses.

## Timing
- Reset values: st_ready 0 during the reset cycle then 1; mem_valid 0, mem_addr 0, mem_wdata 0, mem_we 0, st_done 0, st_err 0; state IDLE.
- All outputs registered. Request accepted at edge N (st_valid & st_ready) -> mem_valid high from cycle N+1.
- mem_valid, mem_addr, mem_wdata, mem_we held stable until the cycle mem_ready=1; beat completes at that edge.
- mem_ready=1 on first cycle: aligned store occupies 1 busy cycle; st_done high cycle N+2; st_ready high N+2. Max throughput: one aligned store per 2 cycles.
- Split store with zero wait: BEAT0 in N+1, BEAT1 in N+2, st_done in N+3.
- st_err high cycle N+1; st_ready high N+2.
- st_ready=0 in BEAT0/BEAT1/ERR; st_valid ignored there.
- mem_ready while mem_valid=0: ignored.
- rst mid-beat: state -> IDLE at that edge, mem_valid drops, no st_done, beat abandoned.

## Configuration
- MISALIGNED_SPLIT_EN defined: crossing stores execute as two beats (BEAT0, BEAT1).
- Not defined: BEAT1 state and +4 adder omitted; crossing stores go to ERR, no memory write, st_err pulses.

## Test plan
- sb addr 0x1003 data 0x000000AB, mem_ready=1 -> one beat addr 0x1000, wdata 0xAB000000, we 4'b1000, st_done at N+2.
- sh addr 0x2002 data 0x0000BEEF, mem_ready held low 3 cycles -> addr 0x2000, wdata 0xBEEF0000, we 4'b1100 stable 4 cycles, single st_done.
- SPLIT on, sw addr 0x3001 data 0x11223344 -> beat0 0x3000 wdata 0x22334400 we 4'b1110; beat1 0x3004 wdata 0x00000011 we 4'b0001; st_done once.
- SPLIT on, sw addr 0xFFFFFFFE data 0xAABBCCDD -> beat0 0xFFFFFFFC we 4'b1100; beat1 0x00000000 wdata 0x0000AABB we 4'b0011.
- SPLIT off, sh addr 0x4003 -> no mem_valid, st_err pulse N+1; st_sel=11 any addr -> same.
- rst asserted during stalled BEAT0 -> next cycle mem_valid 0, no st_done, following sw 0x5000 completes normally.

Source files
------------

// File: rtl/store_aligner.sv
// store_aligner: lane-shifts store data, builds byte write-enables and sequences memory write beats.
// Build option MISALIGNED_SPLIT_EN: word-crossing stores run as two beats instead of being rejected.
module store_aligner (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_sel,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        st_done,
  output logic        st_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Once mem_valid rises, mem_addr/mem_wdata/mem_we stay constant until the edge with mem_ready=1.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_ERR   = 2'd3
  } state_e;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  function automatic logic [3:0] width_mask(input logic [1:0] sel);
    case (sel)
      2'b00:   width_mask = 4'b1111;
      2'b01:   width_mask = 4'b0011;
      2'b10:   width_mask = 4'b0001;
      default: width_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_fill(input logic [3:0] m);
    lane_fill = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Last byte lane touched is off + bytes - 1; reaching lane 4 or beyond means the next word.
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] sel);
    logic [2:0] last;
    case (sel)
      2'b00:   last = {1'b0, off} + 3'd3;
      2'b01:   last = {1'b0, off} + 3'd1;
      default: last = {1'b0, off};
    endcase
    crosses = last[2];
  endfunction

  function automatic logic [3:0] lo_we(input logic [3:0] m, input logic [1:0] off);
    logic [7:0] t;
    t     = {4'b0000, m} << off;
    lo_we = t[3:0];
  endfunction

  function automatic logic [31:0] lo_data(input logic [31:0] d, input logic [1:0] off);
    lo_data = d << {off, 3'b000};
  endfunction

`ifdef MISALIGNED_SPLIT_EN
  function automatic logic [3:0] hi_we(input logic [3:0] m, input logic [1:0] off);
    logic [2:0] rem;
    rem   = 3'd4 - {1'b0, off};
    hi_we = m >> rem;
  endfunction

  function automatic logic [31:0] hi_data(input logic [31:0] d, input logic [1:0] off);
    logic [2:0] rem;
    rem     = 3'd4 - {1'b0, off};
    hi_data = d >> {rem, 3'b000};
  endfunction
`endif

  state_e      state_q, state_d;
  logic        st_ready_q, st_ready_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic        st_done_q, st_done_d;
  logic        st_err_q, st_err_d;

`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mask_q, mask_d;
  logic        cross_q, cross_d;
`endif

  logic [3:0]  req_mask;
  logic [31:0] req_data;
  logic [1:0]  req_off;
  logic        req_cross;
  logic        req_err;

  // Upper bits of rs2 beyond the store width never reach the bus.
  always_comb begin
    req_off   = st_addr[1:0];
    req_mask  = width_mask(st_sel);
    req_data  = st_data & lane_fill(req_mask);
    req_cross = crosses(req_off, st_sel);
    req_err   = (st_sel == 2'b11) || (req_cross && !SplitEn);
  end

  always_comb begin
    state_d     = state_q;
    st_ready_d  = 1'b0;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    st_done_d   = 1'b0;
    st_err_d    = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cross_d     = cross_q;
`endif

    case (state_q)
      S_IDLE: begin
        st_ready_d = 1'b1;
        if (st_valid && st_ready_q) begin
          st_ready_d = 1'b0;
          if (req_err) begin
            state_d  = S_ERR;
            st_err_d = 1'b1;
          end else begin
            state_d     = S_BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {st_addr[31:2], 2'b00};
            mem_wdata_d = lo_data(req_data, req_off);
            mem_we_d    = lo_we(req_mask, req_off);
`ifdef MISALIGNED_SPLIT_EN
            addr_d      = st_addr;
            data_d      = req_data;
            mask_d      = req_mask;
            cross_d     = req_cross;
`endif
          end
        end
      end

      S_BEAT0: begin
        if (mem_ready) begin
`ifdef MISALIGNED_SPLIT_EN
          if (cross_q) begin
            state_d     = S_BEAT1;
            mem_addr_d  = {addr_q[31:2] + 30'd1, 2'b00};
            mem_wdata_d = hi_data(data_q, addr_q[1:0]);
            mem_we_d    = hi_we(mask_q, addr_q[1:0]);
          end else begin
            state_d     = S_IDLE;
            st_ready_d  = 1'b1;
            st_done_d   = 1'b1;
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_we_d    = '0;
          end
`else
          state_d     = S_IDLE;
          st_ready_d  = 1'b1;
          st_done_d   = 1'b1;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_we_d    = '0;
`endif
        end
      end

`ifdef MISALIGNED_SPLIT_EN
      S_BEAT1: begin
        if (mem_ready) begin
          state_d     = S_IDLE;
          st_ready_d  = 1'b1;
          st_done_d   = 1'b1;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_we_d    = '0;
        end
      end
`endif

      S_ERR: begin
        state_d    = S_IDLE;
        st_ready_d = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        st_ready_d  = 1'b1;
        mem_valid_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_ready_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= '0;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_ready_q  <= st_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      st_done_q   <= st_done_d;
      st_err_q    <= st_err_d;
    end
  end

`ifdef MISALIGNED_SPLIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      cross_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      cross_q <= cross_d;
    end
  end
`endif

  assign st_ready  = st_ready_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign st_done   = st_done_q;
  assign st_err    = st_err_q;

endmodule

// File: tb/tb_store_aligner.sv
// tb_store_aligner: random and directed stores checked against a byte-by-byte memory-write model.
// Honours MISALIGNED_SPLIT_EN the same way the design does.
module tb_store_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_sel;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        st_done;
  logic        st_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [31:0] exp_we_q[$];

  store_aligner dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_sel    (st_sel),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .st_done   (st_done),
    .st_err    (st_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  // Walk the store byte by byte; each byte lands in word (a & ~3) at lane a[1:0].
  task automatic model(input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] sel, output bit err);
    int          nbytes;
    int          nb;
    int          lane;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] tmp;
    logic [3:0]  twe;
    logic [31:0] bw_addr[2];
    logic [31:0] bw_data[2];
    logic [3:0]  bw_we[2];
    exp_addr_q.delete();
    exp_wdata_q.delete();
    exp_we_q.delete();
    err = 1'b0;
    nb  = 0;
    case (sel)
      2'b00:   nbytes = 4;
      2'b01:   nbytes = 2;
      2'b10:   nbytes = 1;
      default: nbytes = 0;
    endcase
    if (nbytes == 0) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < nbytes; i++) begin
      a = addr + 32'(i);
      w = a & 32'hFFFF_FFFC;
      if (nb == 0 || bw_addr[nb-1] != w) begin
        bw_addr[nb] = w;
        bw_data[nb] = '0;
        bw_we[nb]   = '0;
        nb++;
      end
      lane = int'(a[1:0]);
      tmp = bw_data[nb-1];
      tmp[8*lane +: 8] = data[8*i +: 8];
      bw_data[nb-1] = tmp;
      twe = bw_we[nb-1];
      twe[lane] = 1'b1;
      bw_we[nb-1] = twe;
    end
`ifndef MISALIGNED_SPLIT_EN
    if (nb > 1) begin
      err = 1'b1;
      return;
    end
`endif
    for (int b = 0; b < nb; b++) begin
      exp_addr_q.push_back(bw_addr[b]);
      exp_wdata_q.push_back(bw_data[b]);
      exp_we_q.push_back({28'd0, bw_we[b]});
    end
  endtask

  task automatic drive_junk();
    st_valid = 1'($urandom_range(0, 1));
    st_addr  = $urandom;
    st_data  = $urandom;
    st_sel   = 2'($urandom_range(0, 3));
  endtask

  // Called at a negedge with the block idle; returns at the negedge where it is idle again.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] sel, input int stall);
    bit          err;
    int          k;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [31:0] ew;
    model(addr, data, sel, err);
    check("ready_before_req", 32'(st_ready), 32'd1);
    st_valid  = 1'b1;
    st_addr   = addr;
    st_data   = data;
    st_sel    = sel;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (err) begin
      check("err_pulse", 32'(st_err), 32'd1);
      check("err_no_valid", 32'(mem_valid), 32'd0);
      check("err_ready_low", 32'(st_ready), 32'd0);
      drive_junk();
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("err_pulse_end", 32'(st_err), 32'd0);
      check("err_ready_back", 32'(st_ready), 32'd1);
      check("err_no_valid2", 32'(mem_valid), 32'd0);
      check("err_no_done", 32'(st_done), 32'd0);
    end else begin
      while (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        ed = exp_wdata_q.pop_front();
        ew = exp_we_q.pop_front();
        k  = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        for (int c = 0; c <= k; c++) begin
          check("beat_valid", 32'(mem_valid), 32'd1);
          check("beat_addr", mem_addr, ea);
          check("beat_wdata", mem_wdata, ed);
          check("beat_we", 32'(mem_we), ew);
          check("beat_no_done", 32'(st_done), 32'd0);
          check("beat_ready_low", 32'(st_ready), 32'd0);
          check("beat_no_err", 32'(st_err), 32'd0);
          drive_junk();
          mem_ready = (c == k);
          @(negedge clk);
        end
      end
      check("done_pulse", 32'(st_done), 32'd1);
      check("done_ready", 32'(st_ready), 32'd1);
      check("done_valid_low", 32'(mem_valid), 32'd0);
    end
    st_valid  = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [31:0] ra;
    rst       = 1'b1;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_sel    = '0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(st_ready), 32'd0);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(st_done), 32'd0);
    check("rst_err", 32'(st_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(st_ready), 32'd1);

    do_store(32'h0000_1003, 32'h0000_00AB, 2'b10, 0);
    do_store(32'h0000_2002, 32'h0000_BEEF, 2'b01, 3);
    do_store(32'h0000_3001, 32'h1122_3344, 2'b00, 0);
    do_store(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b00, 0);
    do_store(32'h0000_4003, 32'h0000_1234, 2'b01, 0);
    do_store(32'h0000_7000, 32'h5555_AAAA, 2'b11, 0);
    do_store(32'h0000_8003, 32'hFFFF_FF5A, 2'b10, 1);
    do_store(32'h0000_9000, 32'hDEAD_BEEF, 2'b00, 0);

    // Reset while a beat is stalled: the beat is abandoned with no completion.
    st_valid  = 1'b1;
    st_addr   = 32'h0000_6000;
    st_data   = 32'h0BAD_F00D;
    st_sel    = 2'b00;
    mem_ready = 1'b0;
    @(negedge clk);
    st_valid = 1'b0;
    check("stall_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(mem_valid), 32'd0);
    check("midrst_done", 32'(st_done), 32'd0);
    check("midrst_ready", 32'(st_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", 32'(st_ready), 32'd1);
    check("midrst_no_done", 32'(st_done), 32'd0);
    do_store(32'h0000_5000, 32'hCAFE_0001, 2'b00, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else ra = $urandom;
      do_store(ra, $urandom, 2'($urandom_range(0, 3)), -1);
      if ($urandom_range(0, 3) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          mem_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("idle_no_valid", 32'(mem_valid), 32'd0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
